// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use, data-stall, flush and HALT control.
// Also drives the fetch hold (hazStall) and keeps a saturating stall counter.
module if_id_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      fInstr,
    input  logic [15:0]      fNextPc,
    input  logic             iMemStall,
    input  logic             flush,
    input  logic             dStall,
    input  logic             exMemRead,
    input  logic [2:0]       exRd,
    output logic             hazStall,
    output logic [15:0]      idInstr,
    output logic [15:0]      idNextPc,
    output logic             idValid,
    output logic             halted,
    output logic [CNT_W-1:0] stallCnt
);

    localparam logic [4:0] OP_HALT = 5'b00000;

    logic [15:0] rInstr;
    logic [15:0] rPc;
    logic        rValid;
    logic        rHalt;

    logic [4:0] opcode;
    logic [2:0] rs;
    logic [2:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic       loadUse;

    assign opcode = rInstr[15:11];
    assign rs     = rInstr[10:8];
    assign rt     = rInstr[7:5];

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        usesRs = 1'b1;
        usesRt = 1'b0;
        case (opcode)
            5'b00000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00110, 5'b11000: usesRs = 1'b0;
            default:                      usesRs = 1'b1;
        endcase
        case (opcode)
            5'b11011, 5'b11010, 5'b11100, 5'b11101,
            5'b11110, 5'b11111, 5'b10000, 5'b10011: usesRt = 1'b1;
            default:                                usesRt = 1'b0;
        endcase
    end

    // Depends only on registered state and downstream inputs, never on fInstr.
    assign loadUse  = rValid & exMemRead &
                      ((usesRs & (rs == exRd)) | (usesRt & (rt == exRd)));
    assign hazStall = loadUse | dStall | rHalt;

    assign idValid  = rValid & ~loadUse & ~dStall;
    assign idInstr  = idValid ? rInstr : NOP_INSTR;
    assign idNextPc = rPc;
    assign halted   = rHalt;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rInstr <= NOP_INSTR;
            rPc    <= '0;
            rValid <= 1'b0;
            rHalt  <= 1'b0;
        end else if (flush) begin
            rInstr <= NOP_INSTR;
            rValid <= 1'b0;
            rHalt  <= 1'b0;
        end else if (dStall || loadUse || rHalt) begin
            rInstr <= rInstr;
        end else if (iMemStall) begin
            rInstr <= NOP_INSTR;
            rValid <= 1'b0;
        end else begin
            rInstr <= fInstr;
            rPc    <= fNextPc;
            rValid <= 1'b1;
            rHalt  <= (fInstr[15:11] == OP_HALT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (hazStall && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (counter narrowed to 4 bits).
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [15:0] fInstr;
    logic [15:0] fNextPc;
    logic        iMemStall;
    logic        flush;
    logic        dStall;
    logic        exMemRead;
    logic [2:0]  exRd;
    logic        hazStall;
    logic [15:0] idInstr;
    logic [15:0] idNextPc;
    logic        idValid;
    logic        halted;
    logic [3:0]  stallCnt;

    int checks = 0;
    int errors = 0;

    if_id_stage #(.NOP_INSTR(16'h0800), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .fInstr   (fInstr),
        .fNextPc  (fNextPc),
        .iMemStall(iMemStall),
        .flush    (flush),
        .dStall   (dStall),
        .exMemRead(exMemRead),
        .exRd     (exRd),
        .hazStall (hazStall),
        .idInstr  (idInstr),
        .idNextPc (idNextPc),
        .idValid  (idValid),
        .halted   (halted),
        .stallCnt (stallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int expCnt;

        // Reset with random inputs, asserted between edges.
        rst       = 1'b1;
        fInstr    = 16'($urandom);
        fNextPc   = 16'($urandom);
        iMemStall = 1'($urandom);
        flush     = 1'($urandom);
        dStall    = 1'b1;
        exMemRead = 1'b1;
        exRd      = 3'($urandom);
        #2 rst = 1'b0;
        #1;
        check("rst_idInstr", 32'(idInstr), 32'h0800);
        check("rst_idValid", 32'(idValid), 32'h0);
        check("rst_stallCnt", 32'(stallCnt), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        tick();
        tick();
        check("rst_hold_stallCnt", 32'(stallCnt), 32'h0);

        // Release and capture first instruction.
        iMemStall = 1'b0;
        flush     = 1'b0;
        dStall    = 1'b0;
        exMemRead = 1'b0;
        exRd      = 3'd0;
        fInstr    = 16'hD8E0;
        fNextPc   = 16'h0002;
        rst       = 1'b1;
        #1;
        check("rel_hazStall", 32'(hazStall), 32'h0);
        tick();
        check("cap_idInstr", 32'(idInstr), 32'hD8E0);
        check("cap_idNextPc", 32'(idNextPc), 32'h0002);
        check("cap_idValid", 32'(idValid), 32'h1);

        // Load-use on rt: ADD rs=1 rt=2, load writes r2.
        fInstr  = 16'hD94C;
        fNextPc = 16'h0004;
        tick();
        exMemRead = 1'b1;
        exRd      = 3'd2;
        fInstr    = 16'h1234;
        fNextPc   = 16'h0006;
        #1;
        check("lu_hazStall", 32'(hazStall), 32'h1);
        check("lu_idValid", 32'(idValid), 32'h0);
        check("lu_idInstr", 32'(idInstr), 32'h0800);
        tick();
        exMemRead = 1'b0;
        #1;
        check("lu_issue_idInstr", 32'(idInstr), 32'hD94C);
        check("lu_issue_idValid", 32'(idValid), 32'h1);
        check("lu_issue_idNextPc", 32'(idNextPc), 32'h0004);
        check("lu_stallCnt", 32'(stallCnt), 32'h1);
        check("lu_issue_hazStall", 32'(hazStall), 32'h0);

        // J uses no source register: no false hazard.
        fInstr  = 16'h2010;
        fNextPc = 16'h0006;
        tick();
        exMemRead = 1'b1;
        exRd      = 3'd0;
        #1;
        check("j_hazStall", 32'(hazStall), 32'h0);
        check("j_idValid", 32'(idValid), 32'h1);
        check("j_idInstr", 32'(idInstr), 32'h2010);

        // Flush beats dStall and an active load-use on rs.
        exMemRead = 1'b0;
        fInstr    = 16'hD94C;
        fNextPc   = 16'h0008;
        tick();
        exMemRead = 1'b1;
        exRd      = 3'd1;
        dStall    = 1'b1;
        flush     = 1'b1;
        #1;
        check("fl_pre_hazStall", 32'(hazStall), 32'h1);
        tick();
        flush     = 1'b0;
        dStall    = 1'b0;
        exMemRead = 1'b0;
        #1;
        check("fl_idInstr", 32'(idInstr), 32'h0800);
        check("fl_idValid", 32'(idValid), 32'h0);
        check("fl_idNextPc", 32'(idNextPc), 32'h0008);
        check("fl_hazStall", 32'(hazStall), 32'h0);
        check("fl_stallCnt", 32'(stallCnt), 32'h2);

        // Three instruction-memory stall cycles give three bubbles.
        iMemStall = 1'b1;
        fInstr    = 16'hD8E0;
        fNextPc   = 16'h000A;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("im_idInstr", 32'(idInstr), 32'h0800);
            check("im_idValid", 32'(idValid), 32'h0);
            check("im_idNextPc", 32'(idNextPc), 32'h0008);
            check("im_hazStall", 32'(hazStall), 32'h0);
        end
        iMemStall = 1'b0;
        tick();
        check("im_resume_idInstr", 32'(idInstr), 32'hD8E0);
        check("im_resume_idNextPc", 32'(idNextPc), 32'h000A);

        // Data-memory stall freezes the stage.
        dStall  = 1'b1;
        fInstr  = 16'h0000;
        fNextPc = 16'h000C;
        #1;
        check("ds_idValid", 32'(idValid), 32'h0);
        check("ds_idInstr", 32'(idInstr), 32'h0800);
        check("ds_hazStall", 32'(hazStall), 32'h1);
        tick();
        dStall = 1'b0;
        #1;
        check("ds_rel_idInstr", 32'(idInstr), 32'hD8E0);
        check("ds_rel_idNextPc", 32'(idNextPc), 32'h000A);
        check("ds_stallCnt", 32'(stallCnt), 32'h3);

        // HALT captured, then freeze with a saturating counter.
        tick();
        check("h_halted", 32'(halted), 32'h1);
        check("h_hazStall", 32'(hazStall), 32'h1);
        check("h_idValid", 32'(idValid), 32'h1);
        check("h_idInstr", 32'(idInstr), 32'h0000);
        check("h_idNextPc", 32'(idNextPc), 32'h000C);
        check("h_stallCnt", 32'(stallCnt), 32'h3);
        fInstr  = 16'hD8E0;
        fNextPc = 16'h000E;
        expCnt  = 3;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (expCnt < 15) expCnt++;
            check("sat_stallCnt", 32'(stallCnt), 32'(expCnt));
        end
        check("sat_final", 32'(stallCnt), 32'hF);
        check("sat_idInstr", 32'(idInstr), 32'h0000);
        check("sat_idNextPc", 32'(idNextPc), 32'h000C);
        check("sat_halted", 32'(halted), 32'h1);

        // Flush clears halt; capture resumes on the following edge.
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        fNextPc = 16'h0010;
        #1;
        check("hf_halted", 32'(halted), 32'h0);
        check("hf_idValid", 32'(idValid), 32'h0);
        check("hf_hazStall", 32'(hazStall), 32'h0);
        tick();
        check("hf_idInstr", 32'(idInstr), 32'hD8E0);
        check("hf_idNextPc", 32'(idNextPc), 32'h0010);
        check("hf_idValid2", 32'(idValid), 32'h1);

        // Asynchronous reset in the middle of a halt.
        fInstr = 16'h0000;
        tick();
        check("ar_pre_halted", 32'(halted), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("ar_halted", 32'(halted), 32'h0);
        check("ar_idValid", 32'(idValid), 32'h0);
        check("ar_idInstr", 32'(idInstr), 32'h0800);
        check("ar_idNextPc", 32'(idNextPc), 32'h0000);
        check("ar_stallCnt", 32'(stallCnt), 32'h0);
        check("ar_hazStall", 32'(hazStall), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Pipeline register and hazard controller between the fetch stage and the decode stage. Captures the 16-bit instruction and PC+2 from fetch, holds them across load-use hazards and downstream data-memory stalls, and inserts NOP bubbles on branch flushes and instruction-memory stalls. Drives the `hazStall` input of fetch, freezes on HALT, and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- `NOP_INSTR`, default 16'h0800: encoding emitted on bubbles.
- `CNT_W`, default 16: width of the stall counter.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `fInstr` in 16: instruction from fetch.
- `fNextPc` in 16: PC+2 from fetch.
- `iMemStall` in 1: fetch has no valid instruction this cycle.
- `flush` in 1: branch/jump resolved taken (fetch `doBranch`).
- `dStall` in 1: data-memory stall from downstream; freeze.
- `exMemRead` in 1: instruction in ID/EX is a load.
- `exRd` in 3: destination register of the ID/EX instruction.
- `hazStall` out 1: combinational; fetch must hold PC.
- `idInstr` out 16: instruction to decode (NOP when `idValid`=0 or bubbling).
- `idNextPc` out 16: PC+2 of `idInstr`.
- `idValid` out 1: `idInstr` is real and may advance this cycle.
- `halted` out 1: HALT captured; stage frozen.
- `stallCnt` out CNT_W: cycles with `hazStall`=1, saturating.

## Operation
- Registered state: `rInstr`[15:0], `rPc`[15:0], `rValid`, `rHalt`, `stallCnt`.
- Opcode = `rInstr[15:11]`; `rs` = `rInstr[10:8]`; `rt` = `rInstr[7:5]`.
- usesRs: opcode not in {00000 HALT, 00001 NOP, 00010, 00011, 00100 J, 00110 JAL, 11000 LBI}.
- usesRt: opcode in {11011, 11010, 11100, 11101, 11110, 11111, 10000 ST, 10011 STU}.
- loadUse = `rValid` & `exMemRead` & ((usesRs & `rs`==`exRd`) | (usesRt & `rt`==`exRd`)).
- `hazStall` = loadUse | `dStall` | `rHalt`.
- Per-edge update, first matching rule wins:
  1. `flush`: `rValid`<=0, `rInstr`<=NOP_INSTR, `rHalt`<=0 (younger HALT discarded). Overrides `dStall` and loadUse.
  2. `dStall`: hold all.
  3. loadUse: hold all (ID instruction retried next cycle).
  4. `rHalt`: hold all.
  5. `iMemStall`: `rValid`<=0, `rInstr`<=NOP_INSTR, `rPc` held.
  6. else: `rInstr`<=`fInstr`, `rPc`<=`fNextPc`, `rValid`<=1, `rHalt`<=(`fInstr[15:11]`==00000).
- Outputs: `idValid` = `rValid` & ~loadUse & ~`dStall`; `idInstr` = `idValid` ? `rInstr` : NOP_INSTR; `idNextPc` = `rPc`; `halted` = `rHalt`.
- `stallCnt` increments each edge where `hazStall`=1 and it is not all-ones; no wrap.

## Timing
- Reset (rst=0, async): `rInstr`=NOP_INSTR, `rPc`=0, `rValid`=0, `rHalt`=0, `stallCnt`=0; hence `idValid`=0, `idInstr`=16'h0800, `hazStall`=0 (once ex inputs are 0).
- Latency: fetch word captured at edge N is on `idInstr` during cycle N+1.
- `hazStall` combinational from registered state and `exMemRead`/`exRd`/`dStall`; no dependence on `fInstr` (no loop with fetch).
- Load-use costs exactly one bubble: the load advances to MEM next edge, `exMemRead` drops, ID instruction issues.
- `flush` and `iMemStall` same cycle: flush rule wins; bubble either way.
- `flush` while `rHalt`=1: halt cleared, capture resumes next edge.
- HALT issues once with `idValid`=1 then stage freezes; `idValid` remains 1 on the held HALT only if not stalled—downstream must not re-execute (decode ignores repeated HALT).
- Reset asserted mid-stall or mid-halt: all state cleared immediately, no edge required.

## Test plan
- Reset: rst=0 with random inputs -> `idInstr`=16'h0800, `idValid`=0, `stallCnt`=0 asynchronously; release, feed 16'hD8E0 PC 16'h0002 -> next cycle `idInstr`=16'hD8E0, `idNextPc`=16'h0002, `idValid`=1.
- Load-use: ID holds ADD 16'hD94C (rs=1, rt=2), `exMemRead`=1, `exRd`=2 -> `hazStall`=1, `idValid`=0, `idInstr`=16'h0800 for one cycle; `exMemRead`=0 next -> 16'hD94C issues, `stallCnt`=1.
- No false hazard: ID holds J 16'h2010, `exMemRead`=1, `exRd`=0 -> `hazStall`=0, `idValid`=1.
- Flush priority: `flush`=1 with `dStall`=1 and loadUse active -> next cycle `rValid`=0, `idInstr`=16'h0800.
- iMem stall: `iMemStall`=1 for 3 cycles -> 3 bubbles, `rPc` unchanged, `hazStall`=0.
- HALT and saturation: feed 16'h0000 -> `halted`=1, `hazStall`=1 thereafter, fetch input ignored; with CNT_W=4, counter stops at 15.
